// File: rtl/complex_mac_sequencer.sv
// Front-end sequencer for a shared multiply-accumulate unit: turns one complex operand pair
// into four real multiply slots and returns the real/imaginary results over valid/ready.
module complex_mac_sequencer #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int RES_WIDTH = 48
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic signed [A_WIDTH-1:0]   IN_AR,
    input  logic signed [A_WIDTH-1:0]   IN_AI,
    input  logic signed [B_WIDTH-1:0]   IN_BR,
    input  logic signed [B_WIDTH-1:0]   IN_BI,
    output logic signed [A_WIDTH-1:0]   MUL_A,
    output logic signed [B_WIDTH-1:0]   MUL_B,
    output logic                        MUL_LOAD,
    output logic                        MUL_ADDSUB,
    input  logic signed [RES_WIDTH-1:0] MUL_RES,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic signed [RES_WIDTH-1:0] OUT_RE,
    output logic signed [RES_WIDTH-1:0] OUT_IM,
    output logic [3:0]                  DBG_STATE
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and a presented result stays stable until it is taken.

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PRE  = 4'd1,
        ST_S0   = 4'd2,
        ST_S1   = 4'd3,
        ST_S2   = 4'd4,
        ST_S3   = 4'd5,
        ST_W0   = 4'd6,
        ST_W1   = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    state_t                      r_state;
    logic                        r_in_ready;
    logic signed [A_WIDTH-1:0]   r_ar;
    logic signed [A_WIDTH-1:0]   r_ai;
    logic signed [B_WIDTH-1:0]   r_br;
    logic signed [B_WIDTH-1:0]   r_bi;
    logic signed [A_WIDTH-1:0]   r_mul_a;
    logic signed [B_WIDTH-1:0]   r_mul_b;
    logic                        r_mul_load;
    logic                        r_mul_addsub;
    logic                        r_out_valid;
    logic signed [RES_WIDTH-1:0] r_out_re;
    logic signed [RES_WIDTH-1:0] r_out_im;
    logic                        w_accept;

    // Ready is only ever set while idle, so it alone qualifies an accept.
    assign w_accept = IN_VALID & r_in_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_ar         <= '0;
            r_ai         <= '0;
            r_br         <= '0;
            r_bi         <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_load   <= 1'b0;
            r_mul_addsub <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
        end else begin
            // Multiplier drive is zero except in the cycles that explicitly set it.
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_load   <= 1'b0;
            r_mul_addsub <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ar       <= IN_AR;
                        r_ai       <= IN_AI;
                        r_br       <= IN_BR;
                        r_bi       <= IN_BI;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_PRE;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_PRE: begin
                    // Control for each slot is issued one cycle ahead of its operands.
                    r_mul_a      <= r_ar;
                    r_mul_b      <= r_br;
                    r_mul_load   <= 1'b1;
                    r_mul_addsub <= 1'b1;
                    r_state      <= ST_S0;
                end
                ST_S0: begin
                    r_mul_a <= r_ai;
                    r_mul_b <= r_bi;
                    r_state <= ST_S1;
                end
                ST_S1: begin
                    r_mul_a    <= r_ar;
                    r_mul_b    <= r_bi;
                    r_mul_load <= 1'b1;
                    r_state    <= ST_S2;
                end
                ST_S2: begin
                    r_mul_a <= r_ai;
                    r_mul_b <= r_br;
                    r_state <= ST_S3;
                end
                ST_S3: begin
                    // ar*br - ai*bi has just settled on the accumulator output.
                    r_out_re <= MUL_RES;
                    r_state  <= ST_W0;
                end
                ST_W0: begin
                    r_state <= ST_W1;
                end
                ST_W1: begin
                    r_out_im    <= MUL_RES;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign IN_READY   = r_in_ready;
    assign MUL_A      = r_mul_a;
    assign MUL_B      = r_mul_b;
    assign MUL_LOAD   = r_mul_load;
    assign MUL_ADDSUB = r_mul_addsub;
    assign OUT_VALID  = r_out_valid;
    assign OUT_RE     = r_out_re;
    assign OUT_IM     = r_out_im;
    assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_complex_mac_sequencer.sv
// Bench for complex_mac_sequencer: behavioural multiply-accumulate model on the MUL_* side,
// complex-product reference model feeding an expected queue, and a monitor popping on output handshakes.
module tb_complex_mac_sequencer;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               IN_VALID = 1'b0;
  logic               IN_READY;
  logic signed [17:0] IN_AR = '0;
  logic signed [17:0] IN_AI = '0;
  logic signed [17:0] IN_BR = '0;
  logic signed [17:0] IN_BI = '0;
  logic signed [17:0] MUL_A;
  logic signed [17:0] MUL_B;
  logic               MUL_LOAD;
  logic               MUL_ADDSUB;
  logic signed [47:0] MUL_RES;
  logic               OUT_VALID;
  logic               OUT_READY = 1'b1;
  logic signed [47:0] OUT_RE;
  logic signed [47:0] OUT_IM;
  logic [3:0]         DBG_STATE;

  complex_mac_sequencer #(.A_WIDTH(18), .B_WIDTH(18), .RES_WIDTH(48)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_AR(IN_AR), .IN_AI(IN_AI), .IN_BR(IN_BR), .IN_BI(IN_BI),
    .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_LOAD(MUL_LOAD), .MUL_ADDSUB(MUL_ADDSUB),
    .MUL_RES(MUL_RES),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RE(OUT_RE), .OUT_IM(OUT_IM),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- multiplier model ----------------
  // Control registered one cycle before the data it governs; result two cycles after data.
  logic [1:0]         m_ctl_q = '0;
  logic [1:0]         m_pctl_q = '0;
  logic signed [35:0] m_prod_q = '0;
  logic signed [47:0] m_res = '0;
  logic signed [47:0] m_ext;
  assign m_ext   = {{12{m_prod_q[35]}}, m_prod_q};
  assign MUL_RES = m_res;

  always @(posedge CLK) begin
    m_ctl_q  <= {MUL_LOAD, MUL_ADDSUB};
    m_prod_q <= MUL_A * MUL_B;
    m_pctl_q <= m_ctl_q;
    m_res    <= (m_pctl_q[1] ? m_res : 48'sd0) + (m_pctl_q[0] ? -m_ext : m_ext);
  end

  // ---------------- reference model / scoreboard ----------------
  logic [95:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int ops_sent = 0;
  int results_seen = 0;
  int last_acc = 0;
  bit stall_en = 1'b0;

  function automatic logic [95:0] ref_mul(input logic signed [17:0] ar, ai, br, bi);
    longint re, im;
    re = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
    im = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
    return {re[47:0], im[47:0]};
  endfunction

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_valid <= 1'b0;
    end else begin
      checks++;
      if (IN_READY && OUT_VALID) begin
        failures++;
        $display("FAIL ready_vs_valid: IN_READY=%0b OUT_VALID=%0b required not both high", IN_READY, OUT_VALID);
      end
      if (OUT_VALID && !prev_valid) begin
        checks++;
        if (cyc - last_acc != 8) begin
          failures++;
          $display("FAIL latency: got %0d cycles required 8", cyc - last_acc);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        logic [95:0] e;
        checks++;
        results_seen++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: re=%0d im=%0d with empty expected queue", OUT_RE, OUT_IM);
        end else begin
          e = exp_q.pop_front();
          if (OUT_RE !== e[95:48] || OUT_IM !== e[47:0]) begin
            failures++;
            $display("FAIL result: got re=%0d im=%0d required re=%0d im=%0d",
                     OUT_RE, OUT_IM, $signed(e[95:48]), $signed(e[47:0]));
          end
        end
      end
      prev_valid <= OUT_VALID;
    end
  end

  // Random consumer back-pressure, changed away from both clock edges.
  always @(posedge CLK) begin
    if (stall_en) begin
      #2 OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic signed [17:0] ar, ai, br, bi, input bit hold, output int acc);
    bit done = 1'b0;
    acc = -1;
    IN_AR = ar; IN_AI = ai; IN_BR = br; IN_BI = bi;
    IN_VALID = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge CLK);
      if (IN_READY) begin
        done = 1'b1;
        acc = cyc;
        last_acc = cyc;
        exp_q.push_back(ref_mul(ar, ai, br, bi));
        ops_sent++;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout: no accept within 300 cycles");
    end
    @(posedge CLK);
    #1;
    if (!hold) IN_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (OUT_VALID) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL valid_timeout: OUT_VALID not seen within 50 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1;
    bit ok;
    logic signed [47:0] cap_re, cap_im;

    // reset state
    #12;
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || MUL_A !== 18'sd0 || MUL_B !== 18'sd0 ||
        MUL_LOAD !== 1'b0 || MUL_ADDSUB !== 1'b0 || OUT_RE !== 48'sd0 || OUT_IM !== 48'sd0) begin
      failures++;
      $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b mul_a=%0d mul_b=%0d re=%0d im=%0d required all 0",
               IN_READY, OUT_VALID, MUL_A, MUL_B, OUT_RE, OUT_IM);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %0b required 1", IN_READY);
    end

    // 1: (3+4j)*(5-2j) = 23+14j
    send_op(18'sd3, 18'sd4, 18'sd5, -18'sd2, 1'b0, a0);
    wait_drain("basic");

    // 2: extreme operands
    send_op(-18'sd131072, 18'sd0, -18'sd131072, 18'sd0, 1'b0, a0);
    wait_drain("min_neg");
    send_op(18'sd131071, 18'sd131071, 18'sd131071, 18'sd131071, 1'b0, a0);
    wait_drain("max_pos");

    // 3: consumer stalls in DONE for 5 cycles
    OUT_READY = 1'b0;
    send_op(-18'sd7, 18'sd9, 18'sd11, -18'sd13, 1'b0, a0);
    wait_valid(ok);
    cap_re = OUT_RE;
    cap_im = OUT_IM;
    IN_AR = 18'sd100; IN_AI = 18'sd100; IN_BR = 18'sd100; IN_BI = 18'sd100;
    IN_VALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_RE !== cap_re || OUT_IM !== cap_im || IN_READY !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: valid=%0b re=%0d im=%0d in_ready=%0b required 1,%0d,%0d,0",
                 OUT_VALID, OUT_RE, OUT_IM, IN_READY, cap_re, cap_im);
      end
    end
    OUT_READY = 1'b1;
    IN_VALID = 1'b0;
    wait_drain("stall");

    // 4: back-to-back with IN_VALID held high
    send_op(18'sd1, 18'sd1, 18'sd1, 18'sd1, 1'b1, a0);
    send_op(18'sd2, -18'sd3, -18'sd1, 18'sd1, 1'b0, a1);
    checks++;
    if (a1 - a0 != 10) begin
      failures++;
      $display("FAIL initiation_interval: got %0d cycles required 10", a1 - a0);
    end
    wait_drain("b2b");

    // 5: asynchronous reset in S1 (third cycle after accept)
    send_op(18'sd123, -18'sd456, 18'sd789, 18'sd321, 1'b0, a0);
    while (cyc < a0 + 3) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || MUL_A !== 18'sd0 || MUL_B !== 18'sd0 ||
        MUL_LOAD !== 1'b0 || MUL_ADDSUB !== 1'b0 || OUT_RE !== 48'sd0 || OUT_IM !== 48'sd0) begin
      failures++;
      $display("FAIL async_reset: in_ready=%0b out_valid=%0b mul_a=%0d mul_b=%0d load=%0b addsub=%0b required all 0",
               IN_READY, OUT_VALID, MUL_A, MUL_B, MUL_LOAD, MUL_ADDSUB);
    end
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    send_op(18'sd7, 18'sd0, 18'sd0, 18'sd6, 1'b0, a0);
    wait_drain("after_reset");

    // 6: random operands with random back-pressure
    stall_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      send_op(18'($urandom_range(0, 262143)), 18'($urandom_range(0, 262143)),
              18'($urandom_range(0, 262143)), 18'($urandom_range(0, 262143)), 1'b0, a0);
    end
    stall_en = 1'b0;
    #3;
    OUT_READY = 1'b1;
    wait_drain("random");

    checks++;
    if (results_seen != ops_sent - 1) begin
      failures++;
      $display("FAIL result_count: got %0d results required %0d", results_seen, ops_sent - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
